// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and FSM states.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  function automatic logic is_iterative(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic is_div_op(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Radix-2 multiply/divide unit owning HI/LO. One shared shift/add-sub datapath,
// magnitude arithmetic during RUN, sign correction and HI/LO write in FIX.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  mdu_state_t       state;
  logic [CW-1:0]    counter;
  logic [WIDTH:0]   acc;       // partial product high half / partial remainder
  logic [WIDTH-1:0] qr;        // multiplier shifting out / dividend in, quotient out
  logic [WIDTH-1:0] opnd;      // |multiplicand| or |divisor|
  logic             div_mode;
  logic             neg_res;   // operand signs differ
  logic             neg_a;     // dividend was negative

  assign busy = (state != ST_IDLE);

  // Launch-time magnitudes and sign flags
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Per-iteration datapath and FIX-stage results
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               div_zero;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can form.
  always_comb begin
    a_neg    = is_signed_op(op) & src_a[WIDTH-1];
    b_neg    = is_signed_op(op) & src_b[WIDTH-1];
    mag_a    = a_neg ? -src_a : src_a;
    mag_b    = b_neg ? -src_b : src_b;

    addend   = qr[0] ? opnd : '0;
    mul_sum  = acc + {1'b0, addend};
    rem_sh   = {acc[WIDTH-1:0], qr[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd});
    rem_diff = rem_sh - {1'b0, opnd};

    prod     = {acc[WIDTH-1:0], qr};
    prod_fix = neg_res ? -prod : prod;
    quot_fix = neg_res ? -qr : qr;
    rem_fix  = neg_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    div_zero = (opnd == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only; the datapath is small
  // enough that resetting all of it costs nothing and keeps simulation X-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      counter  <= '0;
      acc      <= '0;
      qr       <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      neg_res  <= 1'b0;
      neg_a    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (op == MDU_MTHI) begin
              hi <= src_a;
            end else if (op == MDU_MTLO) begin
              lo <= src_a;
            end else if (is_iterative(op)) begin
              acc      <= '0;
              qr       <= mag_a;
              opnd     <= mag_b;
              div_mode <= is_div_op(op);
              neg_res  <= a_neg ^ b_neg;
              neg_a    <= a_neg;
              counter  <= CW'(WIDTH);
              state    <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          if (div_mode) begin
            // Restoring step: keep the subtraction only when it does not go negative
            acc <= rem_ge ? rem_diff : rem_sh;
            qr  <= {qr[WIDTH-2:0], rem_ge};
          end else begin
            acc <= {1'b0, mul_sum[WIDTH:1]};
            qr  <= {mul_sum[0], qr[WIDTH-1:1]};
          end
          counter <= counter - CW'(1);
          if (counter == CW'(1)) state <= ST_FIX;
        end

        ST_FIX: begin
          if (div_mode) begin
            // A zero divisor leaves the dividend as remainder, which rem_fix restores to its raw value
            lo <= div_zero ? '1 : quot_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;
  localparam int LATENCY = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  mdu_op_t      op;
  logic [W-1:0] src_a, src_b;
  logic         busy;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Architectural result of an op, from signed/unsigned 64-bit arithmetic
  function automatic void model(input mdu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                                inout logic [W-1:0] h, inout logic [W-1:0] l);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      MDU_MULT:  begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      MDU_MULTU: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      MDU_DIV: begin
        if (b == '0) begin l = '1; h = a; end
        else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      MDU_DIVU: begin
        if (b == '0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
      end
      MDU_MTHI: h = a;
      MDU_MTLO: l = a;
      default: ;
    endcase
  endfunction

  // Launch one op; if inject is set, present MTHI 0xAB for a few busy cycles
  task automatic do_op(input mdu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit inject);
    int cycles;
    logic [W-1:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    model(o, a, b, m_hi, m_lo);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    if (is_iterative(o)) begin
      if (inject) begin op = MDU_MTHI; src_a = 32'hAB; end
      else op = MDU_NONE;
      cycles = 0;
      while (busy && cycles < 100) begin
        if (cycles == 5) op = MDU_NONE;
        if (cycles == 16) check($sformatf("hold_%s", o.name()), {hi, lo}, {old_hi, old_lo});
        cycles++;
        @(negedge clk);
      end
      op = MDU_NONE;
      check($sformatf("busy_cycles_%s", o.name()), 64'(cycles), 64'(LATENCY));
    end else begin
      op = MDU_NONE;
      check("busy_mt", {63'd0, busy}, 64'd0);
    end
    check($sformatf("hi_%s_%h_%h", o.name(), a, b), {32'd0, hi}, {32'd0, m_hi});
    check($sformatf("lo_%s_%h_%h", o.name(), a, b), {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; op = MDU_NONE; src_a = '0; src_b = '0;
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values with independently known answers
    do_op(MDU_MULT, 32'd7, 32'd6, 1'b0);
    check("mult_7_6_lo", {32'd0, lo}, 64'd42);
    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mult_m1_m1", {hi, lo}, 64'h0000_0000_0000_0001);
    do_op(MDU_DIV, -32'sd7, 32'd2, 1'b0);
    check("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(MDU_DIVU, 32'd100, 32'd0, 1'b0);
    check("divu_by0", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_intmin_m1", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op(MDU_DIV, -32'sd9, 32'd0, 1'b0);
    check("div_neg_by0", {hi, lo}, 64'hFFFF_FFF7_FFFF_FFFF);

    // MTHI while busy is ignored
    do_op(MDU_MTHI, 32'h55, 32'd0, 1'b0);
    do_op(MDU_MTLO, 32'h55, 32'd0, 1'b0);
    do_op(MDU_MULT, 32'd3, 32'd5, 1'b1);
    check("mthi_ignored", {hi, lo}, {32'd0, 32'd15});

    // Reset mid-operation clears everything at once
    do_op(MDU_MTHI, 32'h55, 32'd0, 1'b0);
    do_op(MDU_MTLO, 32'h55, 32'd0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = MDU_MULT; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);
    op = MDU_NONE;
    repeat (9) @(negedge clk);
    check("busy_before_rst", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    do_op(MDU_DIVU, 32'd9, 32'd2, 1'b0);
    check("divu_9_2", {hi, lo}, {32'd1, 32'd4});

    // Idle with start=0, or op=NONE: nothing changes
    @(negedge clk);
    start = 1'b0; op = MDU_MTHI; src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    check("start0_busy", {63'd0, busy}, 64'd0);
    check("start0_hilo", {hi, lo}, {m_hi, m_lo});
    start = 1'b1; op = MDU_NONE;
    @(negedge clk);
    check("op_none_hilo", {hi, lo}, {m_hi, m_lo});
    op = MDU_MULT; start = 1'b0; src_b = 32'd3;
    @(negedge clk);
    check("start0_mult_busy", {63'd0, busy}, 64'd0);
    start = 1'b1; op = MDU_NONE;

    // Randomized mix with occasional zero divisor and INT_MIN operands
    for (int i = 0; i < 40; i++) begin
      mdu_op_t o;
      logic [W-1:0] a, b;
      o = mdu_op_t'($urandom_range(1, 6));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: b = '0;
        1: a = 32'h8000_0000;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      do_op(o, a, b, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
